datapath_io_port: RTL and testbench

- Processor-side I/O responder for StagedDatapath: the end of the IN/OUT interface that the host/bench talks to.
- Buffers host-supplied 16-bit input words and presents the head word on IN for the core's input instruction.
- Captures words written by the core's output instruction into an output FIFO, drained by the host with valid/ready.
- Measures cycles from reset release to the first core output, for run-time reporting.

---
 rtl/datapath_io_port_if.sv | 49 ++++
 rtl/datapath_io_port.sv | 146 ++++++++++++++
 tb/tb_datapath_io_port.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_io_port_if.sv
`default_nettype none
// ============================================================================
// Module      : datapath_io_port_if
// Description : Bus bundle between the host/core side and datapath_io_port.
//               slave  - the I/O port itself (drives IN/OUT, flags, counter)
//               master - the host/core side (drives data, valid/ready, rd/wr)
//               Signals:
//                 host_in_data/valid/ready : host -> input FIFO handshake
//                 core_in_rd, IN, in_empty : core input instruction side
//                 core_out_wr/data         : core output instruction side
//                 OUT, host_out_valid/ready: output FIFO -> host handshake
//                 last_out, cycle_count, done, err_underflow, err_overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface datapath_io_port_if #(
  parameter int CNT_W = 32
);
  logic [15:0]      host_in_data;
  logic             host_in_valid;
  logic             host_in_ready;
  logic             core_in_rd;
  logic [15:0]      IN;
  logic             in_empty;
  logic             core_out_wr;
  logic [15:0]      core_out_data;
  logic [15:0]      OUT;
  logic             host_out_valid;
  logic             host_out_ready;
  logic [15:0]      last_out;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic             err_underflow;
  logic             err_overflow;

  modport slave (
    input  host_in_data, host_in_valid, core_in_rd,
    input  core_out_wr, core_out_data, host_out_ready,
    output host_in_ready, IN, in_empty, OUT, host_out_valid,
    output last_out, cycle_count, done, err_underflow, err_overflow
  );

  modport master (
    output host_in_data, host_in_valid, core_in_rd,
    output core_out_wr, core_out_data, host_out_ready,
    input  host_in_ready, IN, in_empty, OUT, host_out_valid,
    input  last_out, cycle_count, done, err_underflow, err_overflow
  );
endinterface
`default_nettype wire

// File: rtl/datapath_io_port.sv
`default_nettype none
// ============================================================================
// Module      : datapath_io_port
// Description : Processor-side I/O responder. Buffers host words into an
//               input FIFO whose popped word is held on a registered IN,
//               captures core output words into an output FIFO drained by
//               the host, and counts cycles from reset release to the first
//               core output.
//               Ports:
//                 CLK   - clock, all state on rising edge
//                 reset - synchronous, active-high
//                 bus   - datapath_io_port_if.slave (handshakes, data, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_io_port #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  wire logic         CLK,
  input  wire logic         reset,
  datapath_io_port_if.slave bus
);

  localparam int c_IN_AW  = $clog2(IN_DEPTH);
  localparam int c_OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Input FIFO (host -> core)
  // --------------------------------------------------------------------------
  logic [15:0]      r_in_mem [IN_DEPTH];
  logic [c_IN_AW:0] r_in_wp;
  logic [c_IN_AW:0] r_in_rp;
  logic [15:0]      r_in_q;
  logic             r_err_underflow;

  logic w_in_empty;
  logic w_in_full;
  logic w_in_push;
  logic w_in_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_in_empty = (r_in_wp == r_in_rp);
  assign w_in_full  = (r_in_wp[c_IN_AW-1:0] == r_in_rp[c_IN_AW-1:0]) &&
                      (r_in_wp[c_IN_AW] != r_in_rp[c_IN_AW]);
  // Ready depends only on full: no pop-bypass when full.
  assign w_in_push  = bus.host_in_valid && !w_in_full;
  assign w_in_pop   = bus.core_in_rd && !w_in_empty;

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (w_in_push) r_in_mem[r_in_wp[c_IN_AW-1:0]] <= bus.host_in_data;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_in_wp         <= '0;
      r_in_rp         <= '0;
      r_in_q          <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_in_push) r_in_wp <= r_in_wp + 1'b1;
      if (w_in_pop) begin
        r_in_rp <= r_in_rp + 1'b1;
        r_in_q  <= r_in_mem[r_in_rp[c_IN_AW-1:0]];
      end
      // IN is left untouched on an empty read so the core can re-read it.
      if (bus.core_in_rd && w_in_empty) r_err_underflow <= 1'b1;
    end
  end

  assign bus.host_in_ready = !w_in_full;
  assign bus.in_empty      = w_in_empty;
  assign bus.IN            = r_in_q;
  assign bus.err_underflow = r_err_underflow;

  // --------------------------------------------------------------------------
  // Output FIFO (core -> host)
  // --------------------------------------------------------------------------
  logic [15:0]       r_out_mem [OUT_DEPTH];
  logic [c_OUT_AW:0] r_out_wp;
  logic [c_OUT_AW:0] r_out_rp;
  logic [15:0]       r_last_out;
  logic              r_err_overflow;

  logic w_out_empty;
  logic w_out_full;
  logic w_out_push;
  logic w_out_pop;

  assign w_out_empty = (r_out_wp == r_out_rp);
  assign w_out_full  = (r_out_wp[c_OUT_AW-1:0] == r_out_rp[c_OUT_AW-1:0]) &&
                       (r_out_wp[c_OUT_AW] != r_out_rp[c_OUT_AW]);
  assign w_out_pop   = !w_out_empty && bus.host_out_ready;
  // A same-cycle host pop frees the slot, so a write while full still lands.
  assign w_out_push  = bus.core_out_wr && (!w_out_full || w_out_pop);

  always_ff @(posedge CLK) begin
    if (w_out_push) r_out_mem[r_out_wp[c_OUT_AW-1:0]] <= bus.core_out_data;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_out_wp       <= '0;
      r_out_rp       <= '0;
      r_last_out     <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_out_push) r_out_wp <= r_out_wp + 1'b1;
      if (w_out_pop)  r_out_rp <= r_out_rp + 1'b1;
      if (bus.core_out_wr) begin
        r_last_out <= bus.core_out_data;
        if (!w_out_push) r_err_overflow <= 1'b1;
      end
    end
  end

  assign bus.OUT            = w_out_empty ? 16'h0000
                                          : r_out_mem[r_out_rp[c_OUT_AW-1:0]];
  assign bus.host_out_valid = !w_out_empty;
  assign bus.last_out       = r_last_out;
  assign bus.err_overflow   = r_err_overflow;

  // --------------------------------------------------------------------------
  // Run-time counter: counts up to and including the first core write,
  // then freezes; saturates rather than wrapping on very long runs.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (bus.core_out_wr)    r_done <= 1'b1;
    end
  end

  assign bus.cycle_count = r_cnt;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_datapath_io_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_io_port
// Description : Self-checking bench for datapath_io_port. Directed scenarios
//               followed by random traffic, every cycle compared against a
//               queue-based reference model of the port's behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_io_port;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int CNT_W     = 4;   // small so saturation is reachable
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic CLK;
  logic reset;

  datapath_io_port_if #(.CNT_W(CNT_W)) bus ();

  datapath_io_port #(
    .IN_DEPTH (IN_DEPTH),
    .OUT_DEPTH(OUT_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model state
  logic [15:0] m_in_q[$];
  logic [15:0] m_out_q[$];
  logic [15:0] m_in_reg;
  logic [15:0] m_last;
  int          m_cnt;
  bit          m_done;
  bit          m_err_u;
  bit          m_err_o;

  int n_checks;
  int n_fail;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.host_in_data   = '0;
    bus.host_in_valid  = 1'b0;
    bus.core_in_rd     = 1'b0;
    bus.core_out_wr    = 1'b0;
    bus.core_out_data  = '0;
    bus.host_out_ready = 1'b0;
  endtask

  // Advance the model by one cycle using the current inputs, clock the DUT,
  // then compare every output.
  task automatic step();
    bit in_push, in_pop, out_pop, out_push;
    if (reset) begin
      m_in_q.delete();
      m_out_q.delete();
      m_in_reg = '0;
      m_last   = '0;
      m_cnt    = 0;
      m_done   = 0;
      m_err_u  = 0;
      m_err_o  = 0;
    end else begin
      in_push  = bus.host_in_valid && (m_in_q.size() < IN_DEPTH);
      in_pop   = bus.core_in_rd && (m_in_q.size() > 0);
      out_pop  = bus.host_out_ready && (m_out_q.size() > 0);
      out_push = bus.core_out_wr &&
                 ((m_out_q.size() < OUT_DEPTH) || out_pop);
      if (in_pop)  m_in_reg = m_in_q.pop_front();
      if (bus.core_in_rd && !in_pop) m_err_u = 1;
      if (in_push) m_in_q.push_back(bus.host_in_data);
      if (out_pop) void'(m_out_q.pop_front());
      if (out_push) m_out_q.push_back(bus.core_out_data);
      if (bus.core_out_wr) begin
        m_last = bus.core_out_data;
        if (!out_push) m_err_o = 1;
      end
      if (!m_done) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (bus.core_out_wr) m_done = 1;
      end
    end
    @(posedge CLK);
    #1;
    check_value("IN",        32'(bus.IN),             32'(m_in_reg));
    check_value("in_empty",  32'(bus.in_empty),       32'(m_in_q.size() == 0));
    check_value("in_ready",  32'(bus.host_in_ready),  32'(m_in_q.size() < IN_DEPTH));
    check_value("OUT",       32'(bus.OUT),
                m_out_q.size() > 0 ? 32'(m_out_q[0]) : 32'h0);
    check_value("out_valid", 32'(bus.host_out_valid), 32'(m_out_q.size() > 0));
    check_value("last_out",  32'(bus.last_out),       32'(m_last));
    check_value("cycles",    32'(bus.cycle_count),    32'(m_cnt));
    check_value("done",      32'(bus.done),           32'(m_done));
    check_value("err_under", 32'(bus.err_underflow),  32'(m_err_u));
    check_value("err_over",  32'(bus.err_overflow),   32'(m_err_o));
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] words [4];
    logic [15:0] owords [5];
    n_checks = 0;
    n_fail   = 0;
    words  = '{16'h0906, 16'h7540, 16'h0001, 16'h0002};
    owords = '{16'd13, 16'd17, 16'd19, 16'd23, 16'd29};
    idle_inputs();
    reset = 1'b1;
    @(negedge CLK);
    do_reset();
    check_value("rst_in_ready", 32'(bus.host_in_ready), 32'h1);
    check_value("rst_in_empty", 32'(bus.in_empty), 32'h1);

    // Single push then pop
    bus.host_in_valid = 1'b1; bus.host_in_data = 16'h13B0; step();
    idle_inputs(); bus.core_in_rd = 1'b1; step();
    idle_inputs();
    check_value("pop_IN", 32'(bus.IN), 32'h13B0);
    check_value("pop_empty", 32'(bus.in_empty), 32'h1);
    check_value("pop_no_uflow", 32'(bus.err_underflow), 32'h0);

    // Fill, overfill attempt, drain in order
    for (int i = 0; i < 4; i++) begin
      bus.host_in_valid = 1'b1; bus.host_in_data = words[i]; step();
    end
    check_value("full_ready", 32'(bus.host_in_ready), 32'h0);
    bus.host_in_data = 16'hBEEF; step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.core_in_rd = 1'b1; step();
      check_value("drain_IN", 32'(bus.IN), 32'(words[i]));
    end
    step();  // core_in_rd still high, FIFO empty
    idle_inputs();
    check_value("uflow_IN", 32'(bus.IN), 32'h0002);
    check_value("uflow_flag", 32'(bus.err_underflow), 32'h1);

    // Counter saturation without any core output
    do_reset();
    for (int i = 0; i < 20; i++) step();
    check_value("sat_cnt", 32'(bus.cycle_count), 32'(CNT_MAX));
    check_value("sat_done", 32'(bus.done), 32'h0);

    // First output at the 10th cycle after release
    do_reset();
    for (int i = 0; i < 9; i++) step();
    bus.core_out_wr = 1'b1; bus.core_out_data = 16'd11; step();
    idle_inputs();
    check_value("first_OUT", 32'(bus.OUT), 32'd11);
    check_value("first_valid", 32'(bus.host_out_valid), 32'h1);
    check_value("first_done", 32'(bus.done), 32'h1);
    check_value("first_cnt", 32'(bus.cycle_count), 32'd10);
    for (int i = 0; i < 20; i++) step();
    check_value("frozen_cnt", 32'(bus.cycle_count), 32'd10);
    bus.host_out_ready = 1'b1; step();
    idle_inputs();

    // Overflow: five writes, host not ready
    for (int i = 0; i < 5; i++) begin
      bus.core_out_wr = 1'b1; bus.core_out_data = owords[i]; step();
    end
    idle_inputs();
    check_value("ovf_flag", 32'(bus.err_overflow), 32'h1);
    check_value("ovf_last", 32'(bus.last_out), 32'd29);
    for (int i = 0; i < 4; i++) begin
      check_value("ovf_drain", 32'(bus.OUT), 32'(owords[i]));
      bus.host_out_ready = 1'b1; step();
    end
    idle_inputs();
    check_value("ovf_empty", 32'(bus.host_out_valid), 32'h0);

    // Write into a full FIFO while the host pops
    for (int i = 0; i < 4; i++) begin
      bus.core_out_wr = 1'b1; bus.core_out_data = owords[i]; step();
    end
    bus.core_out_data = 16'd31; bus.host_out_ready = 1'b1; step();
    idle_inputs();
    check_value("fullpop_head", 32'(bus.OUT), 32'd17);
    for (int i = 0; i < 4; i++) begin
      check_value("fullpop_drain", 32'(bus.OUT),
                  i == 3 ? 32'd31 : 32'(owords[i+1]));
      bus.host_out_ready = 1'b1; step();
    end
    idle_inputs();

    // Random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      reset              = ($urandom_range(0, 99) == 0);
      bus.host_in_valid  = $urandom_range(0, 1) == 1;
      bus.host_in_data   = 16'($urandom);
      bus.core_in_rd     = $urandom_range(0, 2) == 0;
      bus.core_out_wr    = $urandom_range(0, 3) == 0;
      bus.core_out_data  = 16'($urandom);
      bus.host_out_ready = $urandom_range(0, 2) == 0;
      step();
    end
    reset = 1'b0;

    // Mid-run reset with traffic in flight
    for (int i = 0; i < 6; i++) begin
      bus.host_in_valid = 1'b1; bus.host_in_data = 16'(i + 5);
      bus.core_out_wr = 1'b1; bus.core_out_data = 16'(i + 100);
      bus.core_in_rd = (i == 4);
      step();
    end
    do_reset();
    check_value("mrst_IN", 32'(bus.IN), 32'h0);
    check_value("mrst_OUT", 32'(bus.OUT), 32'h0);
    check_value("mrst_last", 32'(bus.last_out), 32'h0);
    check_value("mrst_valid", 32'(bus.host_out_valid), 32'h0);
    check_value("mrst_empty", 32'(bus.in_empty), 32'h1);
    check_value("mrst_done", 32'(bus.done), 32'h0);
    check_value("mrst_ovf", 32'(bus.err_overflow), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
